// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Bundles the operation input channel, the result output
//                channel and the architectural flag outputs of alu_pipe.
//                master = upstream/downstream side, slave = the ALU itself.
//  Signals     : in_valid/in_ready/opcode/op_a/op_b   (operation channel)
//                out_valid/out_ready/result           (result channel)
//                flag_z/flag_v/flag_n/flags_upd       (flag outputs)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;
    logic             flags_upd;

    // Environment side: presents operations and consumes results.
    modport master (
        output in_valid, opcode, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_v, flag_n, flags_upd
    );

    // ALU side.
    modport slave (
        input  in_valid, opcode, op_a, op_b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_v, flag_n, flags_upd
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered execute-stage ALU. Accepts one operation per
//                valid/ready handshake and presents the result one cycle
//                later on a valid/ready output channel. Keeps Z/V/N flags
//                for the branch unit, updated per opcode class.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus        - alu_pipe_if.slave (operation channel, result
//                             channel, flag outputs)
//  Parameters  : WIDTH      - datapath width (multiple of 8, >= 16)
//                SHW        - shift-amount width, log2(WIDTH)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_bytes = WIDTH / 8;
    localparam int c_lanes = WIDTH / 4;

    localparam logic [3:0] c_op_add    = 4'b0000;
    localparam logic [3:0] c_op_sub    = 4'b0001;
    localparam logic [3:0] c_op_xor    = 4'b0010;
    localparam logic [3:0] c_op_red    = 4'b0011;
    localparam logic [3:0] c_op_sll    = 4'b0100;
    localparam logic [3:0] c_op_sra    = 4'b0101;
    localparam logic [3:0] c_op_ror    = 4'b0110;
    localparam logic [3:0] c_op_paddsb = 4'b0111;
    localparam logic [3:0] c_op_lw     = 4'b1000;
    localparam logic [3:0] c_op_sw     = 4'b1001;
    localparam logic [3:0] c_op_llb    = 4'b1010;
    localparam logic [3:0] c_op_lhb    = 4'b1011;

    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_low_byte = WIDTH'(8'hFF);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_flag_z;
    logic             r_flag_v;
    logic             r_flag_n;
    logic             r_flags_upd;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;

    // The output register can take a new value when it is empty or is
    // being drained in this same cycle, so a continuously-ready consumer
    // sees one result per cycle.
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    // ------------------------------------------------------------------
    // Saturating add / subtract
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_add_sat;
    logic [WIDTH-1:0] w_sub_sat;
    logic             w_sign_a;
    logic             w_sign_b;

    assign w_sign_a = bus.op_a[WIDTH-1];
    assign w_sign_b = bus.op_b[WIDTH-1];
    assign w_sum    = bus.op_a + bus.op_b;
    assign w_diff   = bus.op_a - bus.op_b;

    // Overflow: operands agree in sign (add) or differ (sub) and the
    // result sign departs from A. The clamp direction follows A's sign.
    assign w_add_ovf = (w_sign_a == w_sign_b) & (w_sum[WIDTH-1]  != w_sign_a);
    assign w_sub_ovf = (w_sign_a != w_sign_b) & (w_diff[WIDTH-1] != w_sign_a);

    assign w_add_sat = w_add_ovf ? (w_sign_a ? c_sat_min : c_sat_max) : w_sum;
    assign w_sub_sat = w_sub_ovf ? (w_sign_a ? c_sat_min : c_sat_max) : w_diff;

    // ------------------------------------------------------------------
    // Byte reduction: the full sum of 2*WIDTH/8 signed bytes always fits
    // in WIDTH bits, so a WIDTH-bit wrapping accumulator is exact and
    // already sign-extended.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_red;

    always_comb begin
        w_red = '0;
        for (int i = 0; i < c_bytes; i++) begin
            w_red = w_red
                  + {{(WIDTH-8){bus.op_a[8*i+7]}}, bus.op_a[8*i +: 8]}
                  + {{(WIDTH-8){bus.op_b[8*i+7]}}, bus.op_b[8*i +: 8]};
        end
    end

    // ------------------------------------------------------------------
    // Shifts and rotate
    // ------------------------------------------------------------------
    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_ror_left;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_ror;

    assign w_amt = bus.op_b[SHW-1:0];
    assign w_sll = bus.op_a << w_amt;
    assign w_sra = WIDTH'($signed(bus.op_a) >>> w_amt);

    // Rotate right = right shift OR left shift by the complement. For a
    // zero amount the left shift is by WIDTH, which yields zero, so the
    // result is A unchanged.
    assign w_ror_left = (SHW+1)'(WIDTH) - {1'b0, w_amt};
    assign w_ror      = (bus.op_a >> w_amt) | (bus.op_a << w_ror_left);

    // ------------------------------------------------------------------
    // Packed 4-bit saturating add, lanes fully independent
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_padd;

    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        logic [4:0] w_lane_sum;

        // Sign-extend each nibble by one bit so the 5-bit sum is exact;
        // a disagreement between bits 4 and 3 marks a lane overflow.
        assign w_lane_sum = {bus.op_a[4*g+3], bus.op_a[4*g +: 4]}
                          + {bus.op_b[4*g+3], bus.op_b[4*g +: 4]};

        assign w_padd[4*g +: 4] =
            (w_lane_sum[4] != w_lane_sum[3]) ?
                (w_lane_sum[4] ? 4'b1000 : 4'b0111) :
                w_lane_sum[3:0];
    end

    // ------------------------------------------------------------------
    // Byte loads into A
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_llb;
    logic [WIDTH-1:0] w_lhb;

    assign w_llb = (bus.op_a & ~c_low_byte) | WIDTH'(bus.op_b[7:0]);
    // Bits above 15 are cleared: only A's low byte survives.
    assign w_lhb = (bus.op_a & c_low_byte) | (WIDTH'(bus.op_b[7:0]) << 8);

    // ------------------------------------------------------------------
    // Result select and flag class
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_alu;
    logic             w_ovf;
    logic             w_wr_z;
    logic             w_wr_vn;

    always_comb begin
        w_alu   = bus.op_a;
        w_ovf   = 1'b0;
        w_wr_z  = 1'b0;
        w_wr_vn = 1'b0;
        case (bus.opcode)
            c_op_add: begin
                w_alu   = w_add_sat;
                w_ovf   = w_add_ovf;
                w_wr_z  = 1'b1;
                w_wr_vn = 1'b1;
            end
            c_op_sub: begin
                w_alu   = w_sub_sat;
                w_ovf   = w_sub_ovf;
                w_wr_z  = 1'b1;
                w_wr_vn = 1'b1;
            end
            c_op_xor: begin
                w_alu  = bus.op_a ^ bus.op_b;
                w_wr_z = 1'b1;
            end
            c_op_red:    w_alu = w_red;
            c_op_sll: begin
                w_alu  = w_sll;
                w_wr_z = 1'b1;
            end
            c_op_sra: begin
                w_alu  = w_sra;
                w_wr_z = 1'b1;
            end
            c_op_ror: begin
                w_alu  = w_ror;
                w_wr_z = 1'b1;
            end
            c_op_paddsb: w_alu = w_padd;
            c_op_lw,
            c_op_sw:     w_alu = w_sum;
            c_op_llb:    w_alu = w_llb;
            c_op_lhb:    w_alu = w_lhb;
            default:     w_alu = bus.op_a;   // B / BR / PCS / HLT
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and flags. Nothing changes while a result is held
    // against a stalled consumer, because no accept can happen then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flags_upd <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu;
            r_flags_upd <= w_wr_z;
            if (w_wr_z) begin
                r_flag_z <= (w_alu == '0);
            end
            if (w_wr_vn) begin
                r_flag_v <= w_ovf;
                r_flag_n <= w_alu[WIDTH-1];
            end
        end else begin
            r_flags_upd <= 1'b0;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_v    = r_flag_v;
    assign bus.flag_n    = r_flag_n;
    assign bus.flags_upd = r_flags_upd;

endmodule
`default_nettype wire
